// File: rtl/ahb_reg_responder.sv
// AHB-Lite responder for the PMU register bank: single-word transfers decoded to register strobes.
// Optional AHB_RESP_RO_ERR_EN: writes to read-only indices return ERROR instead of being silently dropped.
module ahb_reg_responder #(
  parameter logic [31:0] HADDR     = 32'h80100000,
  parameter logic [31:0] HMASK     = 32'hfff,
  parameter int          REG_WIDTH = 32,
  parameter int          N_REGS    = 47,
  parameter int          N_WR_REGS = 47,
  localparam int         IDX_W     = $clog2(N_REGS)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 hsel_i,
  input  logic                 hreadyi_i,
  input  logic [31:0]          haddr_i,
  input  logic                 hwrite_i,
  input  logic [1:0]           htrans_i,
  input  logic [2:0]           hsize_i,
  input  logic [REG_WIDTH-1:0] hwdata_i,
  output logic                 hreadyo_o,
  output logic [1:0]           hresp_o,
  output logic [REG_WIDTH-1:0] hrdata_o,
  output logic                 reg_wr_o,
  output logic                 reg_rd_o,
  output logic [IDX_W-1:0]     reg_idx_o,
  output logic [REG_WIDTH-1:0] reg_wdata_o,
  input  logic [REG_WIDTH-1:0] reg_rdata_i
);

  typedef enum logic [2:0] {IDLE, WR, RD_WAIT, RD_DATA, ERR1, ERR2} state_t;

  state_t state, state_n;
  logic [31:0] offset;
  logic [29:0] word;
  logic        ro, err, err_any, accept, wr_ok;
  logic        unused;

  // Base address is informative only; selection comes from hsel_i.
  assign unused = ^{HADDR, htrans_i[0]};

  assign offset = haddr_i & HMASK;
  assign word   = offset[31:2];
  assign ro     = word >= 30'(N_WR_REGS);
  assign err    = (word >= 30'(N_REGS)) || (offset[1:0] != 2'b00) || (hsize_i != 3'b010);
`ifdef AHB_RESP_RO_ERR_EN
  assign err_any = err || (hwrite_i && ro);
`else
  assign err_any = err;
`endif

  // Only completing states (hready high) may open a new address phase.
  assign hreadyo_o = !(state == RD_WAIT || state == ERR1);
  assign accept    = hreadyo_o && hsel_i && hreadyi_i && htrans_i[1];

  always_comb begin
    state_n = IDLE;
    case (state)
      RD_WAIT: state_n = RD_DATA;
      ERR1:    state_n = ERR2;
      default: begin
        if (accept) begin
          if (err_any)       state_n = ERR1;
          else if (hwrite_i) state_n = WR;
          else               state_n = RD_WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      reg_idx_o <= '0;
      wr_ok     <= 1'b0;
      hrdata_o  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        reg_idx_o <= word[IDX_W-1:0];
        wr_ok     <= !ro;
      end
      if (state == RD_WAIT) hrdata_o <= reg_rdata_i;
    end
  end

  assign hresp_o     = (state == ERR1 || state == ERR2) ? 2'b01 : 2'b00;
  assign reg_wr_o    = (state == WR) && wr_ok;
  assign reg_rd_o    = (state == RD_WAIT);
  assign reg_wdata_o = hwdata_i;

endmodule

// File: tb/tb_ahb_reg_responder.sv
// Directed bench for ahb_reg_responder; a second instance with N_WR_REGS=40 covers the read-only window.
module tb_ahb_reg_responder;
  logic        clk = 0;
  logic        rstn;
  logic        hsel, hreadyi, hwrite;
  logic [31:0] haddr, hwdata, rdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;

  logic        hreadyo, wr, rd;
  logic [1:0]  hresp;
  logic [31:0] hrdata, wdata;
  logic [5:0]  idx;

  logic        r_hreadyo, r_wr, r_rd;
  logic [1:0]  r_hresp;
  logic [31:0] r_hrdata, r_wdata;
  logic [5:0]  r_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb_reg_responder dut (
    .clk_i(clk), .rstn_i(rstn), .hsel_i(hsel), .hreadyi_i(hreadyi), .haddr_i(haddr),
    .hwrite_i(hwrite), .htrans_i(htrans), .hsize_i(hsize), .hwdata_i(hwdata),
    .hreadyo_o(hreadyo), .hresp_o(hresp), .hrdata_o(hrdata), .reg_wr_o(wr), .reg_rd_o(rd),
    .reg_idx_o(idx), .reg_wdata_o(wdata), .reg_rdata_i(rdata));

  ahb_reg_responder #(.N_WR_REGS(40)) dut_ro (
    .clk_i(clk), .rstn_i(rstn), .hsel_i(hsel), .hreadyi_i(hreadyi), .haddr_i(haddr),
    .hwrite_i(hwrite), .htrans_i(htrans), .hsize_i(hsize), .hwdata_i(hwdata),
    .hreadyo_o(r_hreadyo), .hresp_o(r_hresp), .hrdata_o(r_hrdata), .reg_wr_o(r_wr), .reg_rd_o(r_rd),
    .reg_idx_o(r_idx), .reg_wdata_o(r_wdata), .reg_rdata_i(rdata));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [1:0] tr);
    hsel = 1'b1; haddr = a; hwrite = w; hsize = sz; htrans = tr;
  endtask

  task automatic idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] err_addr [3];
    logic        err_wr   [3];
    logic [2:0]  err_sz   [3];
    err_addr = '{32'h801000bc, 32'h801000ad, 32'h801000ac};
    err_wr   = '{1'b1, 1'b0, 1'b1};
    err_sz   = '{3'b010, 3'b010, 3'b000};

    rstn = 0; hreadyi = 1; hwdata = 0; rdata = 0; haddr = 0; hsize = 3'b010;
    idle();
    #3;
    chk("rst_hready", 32'(hreadyo), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    tick(); tick();
    rstn = 1;
    tick(); #1;
    chk("idle_hready", 32'(hreadyo), 32'd1);
    chk("idle_strobes", 32'({wr, rd}), 32'd0);

    // single write, idx 43
    bus(32'h801000ac, 1, 3'b010, 2'b10);
    tick(); idle(); hwdata = 32'hcafecafe; #1;
    chk("wr_strobe", 32'(wr), 32'd1);
    chk("wr_idx", 32'(idx), 32'd43);
    chk("wr_wdata", wdata, 32'hcafecafe);
    chk("wr_hready", 32'(hreadyo), 32'd1);
    chk("wr_hresp", 32'(hresp), 32'd0);
    tick(); #1;
    chk("wr_single", 32'(wr), 32'd0);

    // single read, one wait state
    bus(32'h801000ac, 0, 3'b010, 2'b10); rdata = 32'hcafecafe;
    tick(); idle(); #1;
    chk("rd_wait_hready", 32'(hreadyo), 32'd0);
    chk("rd_wait_strobe", 32'(rd), 32'd1);
    chk("rd_wait_nowr", 32'(wr), 32'd0);
    chk("rd_idx", 32'(idx), 32'd43);
    tick(); rdata = 32'h12345678; #1;
    chk("rd_data_hready", 32'(hreadyo), 32'd1);
    chk("rd_data_hresp", 32'(hresp), 32'd0);
    chk("rd_data", hrdata, 32'hcafecafe);
    chk("rd_data_nostrobe", 32'(rd), 32'd0);
    tick(); #1;
    chk("rd_hold", hrdata, 32'hcafecafe);

    // no sampling while bus HREADY is low
    bus(32'h801000ac, 1, 3'b010, 2'b10); hreadyi = 0;
    tick(); idle(); hreadyi = 1; #1;
    chk("hreadyi_low_wr", 32'(wr), 32'd0);
    chk("hreadyi_low_hready", 32'(hreadyo), 32'd1);

    // error cases: bad index, unaligned, bad size
    for (int i = 0; i < 3; i++) begin
      bus(err_addr[i], err_wr[i], err_sz[i], 2'b10);
      tick(); idle(); #1;
      chk($sformatf("err%0d_1_hready", i), 32'(hreadyo), 32'd0);
      chk($sformatf("err%0d_1_hresp", i), 32'(hresp), 32'd1);
      chk($sformatf("err%0d_1_strobes", i), 32'({wr, rd}), 32'd0);
      tick(); #1;
      chk($sformatf("err%0d_2_hready", i), 32'(hreadyo), 32'd1);
      chk($sformatf("err%0d_2_hresp", i), 32'(hresp), 32'd1);
      chk($sformatf("err%0d_2_strobes", i), 32'({wr, rd}), 32'd0);
      tick(); #1;
      chk($sformatf("err%0d_done_hresp", i), 32'(hresp), 32'd0);
    end

    // back-to-back writes, idx 44..46
    bus(32'h801000b0, 1, 3'b010, 2'b10);
    tick(); bus(32'h801000b4, 1, 3'b010, 2'b11); hwdata = 32'hd0d0d0d0; #1;
    chk("b2b0_wr", 32'(wr), 32'd1);
    chk("b2b0_idx", 32'(idx), 32'd44);
    chk("b2b0_wdata", wdata, 32'hd0d0d0d0);
    chk("b2b0_hready", 32'(hreadyo), 32'd1);
    tick(); bus(32'h801000b8, 1, 3'b010, 2'b11); hwdata = 32'hd1d1d1d1; #1;
    chk("b2b1_wr", 32'(wr), 32'd1);
    chk("b2b1_idx", 32'(idx), 32'd45);
    chk("b2b1_hready", 32'(hreadyo), 32'd1);
    tick(); bus(32'h801000bc, 1, 3'b010, 2'b00); hwdata = 32'hd2d2d2d2; #1;
    chk("b2b2_wr", 32'(wr), 32'd1);
    chk("b2b2_idx", 32'(idx), 32'd46);
    chk("b2b2_wdata", wdata, 32'hd2d2d2d2);
    tick(); #1;
    chk("idle_trans_wr", 32'(wr), 32'd0);
    chk("idle_trans_hready", 32'(hreadyo), 32'd1);
    chk("idle_trans_hresp", 32'(hresp), 32'd0);
    idle(); tick(); tick(); tick(); tick();

    // write followed by read without a bubble
    bus(32'h801000a0, 1, 3'b010, 2'b10);
    tick(); bus(32'h801000a0, 0, 3'b010, 2'b10); hwdata = 32'h55; #1;
    chk("w2r_wr", 32'(wr), 32'd1);
    chk("w2r_idx", 32'(idx), 32'd40);
    tick(); idle(); rdata = 32'haaaa5555; #1;
    chk("w2r_rd", 32'(rd), 32'd1);
    chk("w2r_wait", 32'(hreadyo), 32'd0);
    chk("w2r_nowr", 32'(wr), 32'd0);
    tick(); #1;
    chk("w2r_data", hrdata, 32'haaaa5555);
    chk("w2r_hready", 32'(hreadyo), 32'd1);
    tick(); tick(); tick(); tick();

    // read-only window on the N_WR_REGS=40 instance, idx 45
    bus(32'h801000b4, 1, 3'b010, 2'b10);
    tick(); idle(); hwdata = 32'h77; #1;
    chk("ro_wr", 32'(r_wr), 32'd0);
    chk("rw_wr", 32'(wr), 32'd1);
    chk("rw_idx", 32'(idx), 32'd45);
`ifdef AHB_RESP_RO_ERR_EN
    chk("ro_err1_hready", 32'(r_hreadyo), 32'd0);
    chk("ro_err1_hresp", 32'(r_hresp), 32'd1);
    tick(); #1;
    chk("ro_err2_hready", 32'(r_hreadyo), 32'd1);
    chk("ro_err2_hresp", 32'(r_hresp), 32'd1);
    chk("ro_err2_wr", 32'(r_wr), 32'd0);
`else
    chk("ro_drop_hready", 32'(r_hreadyo), 32'd1);
    chk("ro_drop_hresp", 32'(r_hresp), 32'd0);
    tick(); #1;
    chk("ro_after_hresp", 32'(r_hresp), 32'd0);
    chk("ro_after_wr", 32'(r_wr), 32'd0);
`endif
    tick(); tick(); tick();

    // asynchronous reset during RD_WAIT
    bus(32'h801000ac, 0, 3'b010, 2'b10); rdata = 32'h0badf00d;
    tick(); idle(); #1;
    chk("rst_rd_pre", 32'(rd), 32'd1);
    rstn = 0; #1;
    chk("rst_rd_drop", 32'(rd), 32'd0);
    chk("rst_rd_hready", 32'(hreadyo), 32'd1);
    chk("rst_rd_hresp", 32'(hresp), 32'd0);
    chk("rst_rd_hrdata", hrdata, 32'd0);
    tick(); rstn = 1;
    tick(); #1;
    chk("rst_rd_idle_hready", 32'(hreadyo), 32'd1);
    chk("rst_rd_idle_strobes", 32'({wr, rd}), 32'd0);
    chk("rst_rd_idle_hrdata", hrdata, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
